// File: rtl/hmmm_pkg.sv
// hmmm_pkg: definitions shared by the HMMM memory loader and the core datapath.
//   HMMM_WORD_W : RAM / ReadData word width (7 high bits + 8 low bits per word)
//   HMMM_ADDR_W : word address width; RAM depth is 2**HMMM_ADDR_W
//   ld_state_e  : boot-loader state encoding
package hmmm_pkg;

    localparam int HMMM_WORD_W = 15;
    localparam int HMMM_ADDR_W = 8;

    // LOAD_HI: waiting for the high byte of a word
    // LOAD_LO: waiting for the low byte; the word is written when it lands
    // RUN    : image complete, core owns the RAM port
    typedef enum logic [1:0] {
        LOAD_HI = 2'd0,
        LOAD_LO = 2'd1,
        RUN     = 2'd2
    } ld_state_e;

endpackage

// File: rtl/ram_1rw.sv
// ram_1rw: single-port synchronous RAM, read-first, registered output.
//   clk    : clock, all activity on rising edge
//   reset  : asynchronous active-low reset of the output register only
//   rd_en  : 1 = capture mem[addr] into rdata, 0 = load rdata with zero
//   we     : write strobe for mem[addr] <= wdata
//   addr   : word address
//   wdata  : write data
//   rdata  : registered read data
// The array itself is never reset so it can map onto block RAM; only the
// output register is, which lets the top hold ReadData at zero while loading.
module ram_1rw #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
    end

    // Nonblocking read of mem sees the pre-write contents: read-first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rdata <= '0;
        else if (rd_en)
            rdata <= mem[addr];
        else
            rdata <= '0;
    end

endmodule

// File: rtl/hmmm_mem_loader.sv
// hmmm_mem_loader: memory-side responder for the 8-bit HMMM core bus plus a
// boot loader that fills the unified RAM from a byte stream (high byte, then
// low byte, per word) and then releases the core through cpu_run.
//   clk, reset          : clock / asynchronous active-low reset
//   MemWrite, adr,      : core store strobe, word address, store data
//   WriteData           :
//   ReadData            : registered read data to the core (0 while loading)
//   ld_valid, ld_data,  : load byte stream; ld_last marks the final byte
//   ld_last, ld_ready   :
//   reload              : single-cycle request to restart loading
//   cpu_run             : high while the core may run
//   ld_err              : sticky image-format error
//   ld_count            : words written during the current load
module hmmm_mem_loader
    import hmmm_pkg::*;
#(
    parameter int ADDR_W = HMMM_ADDR_W,
    parameter int WORD_W = HMMM_WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] adr,
    input  logic [7:0]        WriteData,
    output logic [WORD_W-1:0] ReadData,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              reload,
    output logic              cpu_run,
    output logic              ld_err,
    output logic [ADDR_W:0]   ld_count
);

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] load_addr_q, load_addr_d;
    logic [6:0]        hi_q, hi_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              run_q;
    logic              xfer;
    logic              ld_we;
    logic              in_run;
    logic              last_addr;

    logic              ram_we;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [WORD_W-1:0] ram_wdata;

    assign in_run    = (state_q == RUN);
    assign ld_ready  = ~in_run;
    // reload wins over a coincident byte: the byte is simply not taken.
    assign xfer      = ld_valid & ld_ready & ~reload;
    assign last_addr = (load_addr_q == {ADDR_W{1'b1}});

    always_comb begin
        state_d     = state_q;
        load_addr_d = load_addr_q;
        hi_d        = hi_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        ld_we       = 1'b0;
        if (reload) begin
            state_d     = LOAD_HI;
            load_addr_d = '0;
            cnt_d       = '0;
            err_d       = 1'b0;
        end else if (xfer) begin
            case (state_q)
                LOAD_HI: begin
                    hi_d = ld_data[6:0];
                    if (ld_data[7])
                        err_d = 1'b1;
                    // A last byte in the high slot means an odd-length image:
                    // flag it and release the core without writing a half word.
                    if (ld_last) begin
                        err_d   = 1'b1;
                        state_d = RUN;
                    end else begin
                        state_d = LOAD_LO;
                    end
                end
                LOAD_LO: begin
                    ld_we       = 1'b1;
                    cnt_d       = cnt_q + (ADDR_W+1)'(1);
                    load_addr_d = load_addr_q + ADDR_W'(1);
                    if (ld_last) begin
                        state_d = RUN;
                    end else if (last_addr) begin
                        // RAM full but the stream did not end: truncated image.
                        err_d   = 1'b1;
                        state_d = RUN;
                    end else begin
                        state_d = LOAD_HI;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= LOAD_HI;
            load_addr_q <= '0;
            hi_q        <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_addr_q <= load_addr_d;
            hi_q        <= hi_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            run_q       <= (state_d == RUN);
        end
    end

    // Single RAM port: loader owns it until RUN, then the core does. A core
    // store coinciding with reload is dropped since the core is being reset.
    always_comb begin
        if (in_run) begin
            ram_addr  = adr;
            ram_we    = MemWrite & ~reload;
            ram_wdata = WORD_W'(WriteData);
        end else begin
            ram_addr  = load_addr_q;
            ram_we    = ld_we;
            ram_wdata = WORD_W'({hi_q, ld_data});
        end
    end

    // Reads only count while RUN persists, so ReadData is zero whenever the
    // loader is (or is about to be) active.
    assign ram_rd_en = in_run & ~reload;

    ram_1rw #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .rd_en (ram_rd_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ReadData)
    );

    assign cpu_run  = run_q;
    assign ld_err   = err_q;
    assign ld_count = cnt_q;

endmodule

// File: tb/tb_hmmm_mem_loader.sv
// tb_hmmm_mem_loader: self-checking bench for hmmm_mem_loader.
// Inputs change just after the falling edge; outputs are sampled there too.
module tb_hmmm_mem_loader;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [7:0]  adr;
    logic [7:0]  WriteData;
    logic [14:0] ReadData;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        reload;
    logic        cpu_run;
    logic        ld_err;
    logic [8:0]  ld_count;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        we;
        logic [7:0]  adr;
        logic [7:0]  wd;
        logic        ck;
        logic [14:0] exp;
    } vec_t;

    vec_t        vecs[9];
    logic [14:0] sb[$];

    hmmm_mem_loader dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .adr       (adr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .reload    (reload),
        .cpu_run   (cpu_run),
        .ld_err    (ld_err),
        .ld_count  (ld_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        ld_valid = 1'b1;
        ld_data  = b;
        ld_last  = last;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        step();
        reload = 1'b0;
    endtask

    // One core bus cycle; expected read data goes through the scoreboard.
    task automatic core_op(input logic we, input logic [7:0] a, input logic [7:0] wd,
                           input logic ck, input logic [14:0] exp);
        logic [14:0] e;
        MemWrite  = we;
        adr       = a;
        WriteData = wd;
        if (ck) sb.push_back(exp);
        step();
        MemWrite = 1'b0;
        if (ck) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk($sformatf("rd@%02h", a), 32'(ReadData), 32'(e));
            end
        end
    endtask

    // Word i of the full-depth image.
    function automatic logic [14:0] fw(input int i);
        logic [7:0] lo;
        lo = 8'(i) ^ 8'h5A;
        return {7'(i * 3), lo};
    endfunction

    initial begin
        vecs[0] = '{1'b0, 8'h01, 8'h00, 1'b1, 15'h0567};
        vecs[1] = '{1'b0, 8'h00, 8'h00, 1'b1, 15'h1234};
        vecs[2] = '{1'b1, 8'h10, 8'hA5, 1'b0, 15'h0000};
        vecs[3] = '{1'b0, 8'h10, 8'h00, 1'b1, 15'h00A5};
        vecs[4] = '{1'b1, 8'h10, 8'h3C, 1'b1, 15'h00A5};  // read-first
        vecs[5] = '{1'b0, 8'h10, 8'h00, 1'b1, 15'h003C};
        vecs[6] = '{1'b1, 8'hFF, 8'h80, 1'b0, 15'h0000};
        vecs[7] = '{1'b0, 8'hFF, 8'h00, 1'b1, 15'h0080};
        vecs[8] = '{1'b0, 8'h01, 8'h00, 1'b1, 15'h0567};

        reset = 1'b0; MemWrite = 1'b0; adr = '0; WriteData = '0;
        ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; reload = 1'b0;
        step();
        step();
        chk("rst_rdata",  32'(ReadData), 32'h0);
        chk("rst_run",    32'(cpu_run),  32'h0);
        chk("rst_err",    32'(ld_err),   32'h0);
        chk("rst_count",  32'(ld_count), 32'h0);
        chk("rst_ready",  32'(ld_ready), 32'h1);
        reset = 1'b1;

        // Basic two-word image
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        send(8'h05, 1'b0);
        chk("ld1_run_pre", 32'(cpu_run), 32'h0);
        chk("ld1_rd_zero", 32'(ReadData), 32'h0);
        send(8'h67, 1'b1);
        chk("ld1_run",   32'(cpu_run),  32'h1);
        chk("ld1_count", 32'(ld_count), 32'h2);
        chk("ld1_err",   32'(ld_err),   32'h0);
        chk("ld1_ready", 32'(ld_ready), 32'h0);

        foreach (vecs[i])
            core_op(vecs[i].we, vecs[i].adr, vecs[i].wd, vecs[i].ck, vecs[i].exp);

        // Odd-length image; core store while loading must be ignored
        do_reload();
        chk("odd_ready0", 32'(ld_ready), 32'h1);
        chk("odd_run0",   32'(cpu_run),  32'h0);
        core_op(1'b1, 8'h00, 8'hEE, 1'b0, 15'h0);
        chk("odd_rd_zero", 32'(ReadData), 32'h0);
        send(8'h01, 1'b1);
        chk("odd_err",   32'(ld_err),   32'h1);
        chk("odd_run",   32'(cpu_run),  32'h1);
        chk("odd_count", 32'(ld_count), 32'h0);
        core_op(1'b0, 8'h00, 8'h00, 1'b1, 15'h1234);
        core_op(1'b0, 8'h01, 8'h00, 1'b1, 15'h0567);

        // High byte with bit 7 set
        do_reload();
        send(8'h80, 1'b0);
        chk("hi80_err", 32'(ld_err),  32'h1);
        chk("hi80_run", 32'(cpu_run), 32'h0);
        send(8'h42, 1'b1);
        chk("hi80_count", 32'(ld_count), 32'h1);
        chk("hi80_run2",  32'(cpu_run),  32'h1);
        core_op(1'b0, 8'h00, 8'h00, 1'b1, 15'h0042);
        core_op(1'b0, 8'h01, 8'h00, 1'b1, 15'h0567);

        // Full-depth image without ld_last
        do_reload();
        for (int i = 0; i < 256; i++) begin
            send({1'b0, 7'(i * 3)}, 1'b0);
            send(8'(i) ^ 8'h5A, 1'b0);
            if (i == 254) begin
                chk("full_run_254",   32'(cpu_run),  32'h0);
                chk("full_ready_254", 32'(ld_ready), 32'h1);
                chk("full_count_254", 32'(ld_count), 32'd255);
            end
        end
        chk("full_count", 32'(ld_count), 32'd256);
        chk("full_err",   32'(ld_err),   32'h1);
        chk("full_ready", 32'(ld_ready), 32'h0);
        chk("full_run",   32'(cpu_run),  32'h1);
        send(8'h00, 1'b1);  // not accepted in RUN
        chk("full_count_hold", 32'(ld_count), 32'd256);
        chk("full_err_hold",   32'(ld_err),   32'h1);
        core_op(1'b0, 8'h00, 8'h00, 1'b1, fw(0));
        core_op(1'b0, 8'h01, 8'h00, 1'b1, fw(1));
        core_op(1'b0, 8'h80, 8'h00, 1'b1, fw(128));
        core_op(1'b0, 8'hFF, 8'h00, 1'b1, fw(255));

        // reload coinciding with a valid byte: byte dropped
        reload   = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 8'h7F;
        step();
        reload   = 1'b0;
        ld_valid = 1'b0;
        chk("rl_run",   32'(cpu_run),  32'h0);
        chk("rl_ready", 32'(ld_ready), 32'h1);
        chk("rl_count", 32'(ld_count), 32'h0);
        chk("rl_err",   32'(ld_err),   32'h0);
        send(8'h01, 1'b0);
        chk("rl_count_hi", 32'(ld_count), 32'h0);
        send(8'h23, 1'b1);
        chk("rl_run2",   32'(cpu_run),  32'h1);
        chk("rl_count2", 32'(ld_count), 32'h1);
        core_op(1'b0, 8'h00, 8'h00, 1'b1, 15'h0123);
        core_op(1'b0, 8'h01, 8'h00, 1'b1, fw(1));

        // Asynchronous reset in LOAD_LO
        do_reload();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        send(8'h55, 1'b0);
        chk("ar_count_pre", 32'(ld_count), 32'h2);
        #2 reset = 1'b0;
        #1;
        chk("ar_ready", 32'(ld_ready), 32'h1);
        chk("ar_run",   32'(cpu_run),  32'h0);
        chk("ar_count", 32'(ld_count), 32'h0);
        chk("ar_err",   32'(ld_err),   32'h0);
        @(negedge clk);
        reset = 1'b1;
        send(8'h66, 1'b0);
        send(8'h77, 1'b1);
        chk("ar_run2",   32'(cpu_run),  32'h1);
        chk("ar_count2", 32'(ld_count), 32'h1);
        core_op(1'b0, 8'h00, 8'h00, 1'b1, 15'h6677);
        core_op(1'b0, 8'h01, 8'h00, 1'b1, 15'h3344);
        core_op(1'b0, 8'h02, 8'h00, 1'b1, fw(2));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hmmm_mem_loader.md
Name: hmmm_mem_loader

Overview:
- Memory-side responder for the 8-bit HMMM core bus (MemWrite, adr, WriteData in; ReadData out).
- Owns the unified instruction/data RAM.
- Also runs a boot-load FSM that fills the RAM from a byte stream, then releases the core via cpu_run.
- Sits between the top-level core and the board-level program source.

Parameters:
ADDR_W, 8, address width; RAM depth = 2**ADDR_W words
WORD_W, 15, RAM word width; equals core ReadData width

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
MemWrite  in  1  core store strobe
adr  in  ADDR_W  core word address (fetch or data)
WriteData  in  8  core store data
ReadData  out  WORD_W  registered read data to core
ld_valid  in  1  load byte valid
ld_data  in  8  load byte
ld_last  in  1  marks final byte of image, qualified by ld_valid
ld_ready  out  1  loader can accept a byte
reload  in  1  single-cycle request to restart loading
cpu_run  out  1  high = core may run; top drives core reset from ~cpu_run
ld_err  out  1  sticky load-format error
ld_count  out  ADDR_W+1  words written during current load

Behaviour:
- Reset (reset=0, asynchronous) forces the following:
  - state=LOAD_HI, ReadData=0, cpu_run=0, ld_err=0, ld_count=0.
  - Internal load address and hi-byte holding register = 0.
  - RAM contents are not cleared.
- States: LOAD_HI, LOAD_LO, RUN. ld_ready = (state != RUN), driven combinationally from state.
- Byte transfer occurs on a rising edge where ld_valid & ld_ready are both high. With no transfer, state holds.
- LOAD_HI transfer:
  - Latch ld_data[6:0] as word high bits.
  - ld_data[7]=1 sets ld_err; the bit is dropped.
  - ld_last=1 here is an odd-length image: set ld_err, go to RUN, write nothing.
  - Otherwise go to LOAD_LO.
- LOAD_LO transfer:
  - Write RAM[load_addr] <= {hi[6:0], ld_data}; ld_count++; load_addr++.
  - Go to RUN if ld_last=1.
  - Also go to RUN if load_addr was 2**ADDR_W-1. In that case, if ld_last=0, set ld_err (image truncated at full depth).
  - Otherwise go to LOAD_HI.
- cpu_run is registered: it is 1 exactly when state==RUN, so it rises the cycle after the final word write.
- RUN read path:
  - ReadData <= RAM[adr] every cycle; 1-cycle latency.
  - Read-during-write to the same address returns the old data (read-first).
- RUN write path:
  - MemWrite=1 writes RAM[adr] <= {(WORD_W-8) zeros, WriteData}.
- Outside RUN:
  - MemWrite is ignored.
  - ReadData is held at 0.
- reload=1 in any state, synchronously:
  - Go to LOAD_HI; clear load_addr, ld_count and ld_err; drop cpu_run next edge.
  - reload has priority over a simultaneous byte transfer, which is discarded (not accepted).
- ld_err stays high until reset or reload.
- ld_count saturates naturally at 2**ADDR_W; it does not wrap because loading ends at full depth.
- Reset asserted mid-load or mid-run aborts immediately to the reset state. Partially written RAM is kept.

Decomposition:
- Shared package hmmm_pkg:
  - typedef enum for loader state {LOAD_HI, LOAD_LO, RUN}.
  - localparams HMMM_WORD_W=15 and HMMM_ADDR_W=8, reused by the core datapath.
- One sub-module: ram_1rw, a single-port synchronous RAM (WORD_W x 2**ADDR_W, read-first, registered output).
- The top-level mux selects between the loader write port and the core address/write port by state.

Test Plan:
- After reset release, stream bytes 0x12,0x34,0x05,0x67 with ld_last on 0x67 -> RAM[0]=0x1234, RAM[1]=0x0567; ld_count=2; cpu_run=1 one cycle after the 0x67 transfer; ld_err=0.
- In RUN, drive adr=0x01 -> ReadData=0x0567 one cycle later; MemWrite=1, adr=0x10, WriteData=0xA5 -> next read of 0x10 returns 0x00A5.
- Stream a single byte 0x01 with ld_last=1 -> ld_err=1, cpu_run=1, ld_count=0, no RAM write. Separately, a hi byte 0x80 -> ld_err=1 and the stored hi bits are 0x00.
- Stream 256 words with ld_last never set -> after word 255 is written, state=RUN, ld_count=256, ld_err=1, ld_ready=0.
- In RUN, pulse reload together with ld_valid=1 -> byte not accepted; next cycle cpu_run=0, ld_ready=1, ld_count=0, ld_err=0; a new load overwrites RAM[0].
- Assert reset while in LOAD_LO -> ld_ready=1, cpu_run=0 and ld_count=0 immediately (asynchronously). Words already written stay readable after the next load completes.
